// File: rtl/char_rom_arbiter_if.sv
// Bus between two glyph-line requesters, the shared char ROM and the arbiter.
// The master side drives the requests and the ROM result; the slave side is the arbiter.
interface char_rom_arbiter_if;
  logic        req0;
  logic        req1;
  logic        lock0;
  logic        lock1;
  logic [7:0]  xy0;
  logic [7:0]  xy1;
  logic [3:0]  line0;
  logic [3:0]  line1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [10:0] rdata0;
  logic [10:0] rdata1;
  logic [7:0]  rom_xy;
  logic [3:0]  rom_line;
  logic [10:0] rom_code;

  modport master (
    output req0, req1, lock0, lock1, xy0, xy1, line0, line1, rom_code,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_xy, rom_line
  );

  modport slave (
    input  req0, req1, lock0, lock1, xy0, xy1, line0, line1, rom_code,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_xy, rom_line
  );
endinterface

// File: rtl/char_rom_arbiter.sv
// Two-port arbiter in front of a combinational char ROM: lockable ownership,
// round-robin or fixed priority, fixed two-cycle lookup latency with tag routing.
module char_rom_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  char_rom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [4:0] LOCK_MAX = 5'd16;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [4:0]  lock_cnt_q, lock_cnt_d;
  logic        gnt0, gnt1;
  logic        gnt_lock;
  logic [4:0]  cnt_next;

  logic [7:0]  rom_xy_q, rom_xy_d;
  logic [3:0]  rom_line_q, rom_line_d;
  logic        tag_vld_q, tag_vld_d;
  logic        tag_port_q, tag_port_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [10:0] rdata0_q, rdata0_d;
  logic [10:0] rdata1_q, rdata1_d;

  always_comb begin
    state_d    = IDLE;
    last_d     = last_q;
    lock_cnt_d = 5'd0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    cnt_next   = 5'd1;
    case (state_q)
      OWN0: begin
        gnt0 = bus.req0;
        gnt1 = !bus.req0 && bus.req1;
      end
      OWN1: begin
        gnt1 = bus.req1;
        gnt0 = !bus.req1 && bus.req0;
      end
      default: begin
        if (bus.req0 && bus.req1) begin
          // last_q names the port granted most recently, so the other one wins.
          gnt0 = RR_EN ? last_q : 1'b1;
          gnt1 = !gnt0;
        end else begin
          gnt0 = bus.req0;
          gnt1 = bus.req1;
        end
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    // The burst count only continues while the current owner keeps being granted.
    if ((state_q == OWN0 && gnt0) || (state_q == OWN1 && gnt1))
      cnt_next = lock_cnt_q + 5'd1;
    gnt_lock = gnt0 ? bus.lock0 : bus.lock1;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (gnt_lock && cnt_next != LOCK_MAX) begin
        state_d    = gnt0 ? OWN0 : OWN1;
        lock_cnt_d = cnt_next;
      end
    end
  end

  always_comb begin
    rom_xy_d   = rom_xy_q;
    rom_line_d = rom_line_q;
    if (gnt0) begin
      rom_xy_d   = bus.xy0;
      rom_line_d = bus.line0;
    end else if (gnt1) begin
      rom_xy_d   = bus.xy1;
      rom_line_d = bus.line1;
    end
    tag_vld_d  = gnt0 || gnt1;
    tag_port_d = gnt1;
    rvalid0_d  = tag_vld_q && !tag_port_q;
    rvalid1_d  = tag_vld_q && tag_port_q;
    rdata0_d   = rvalid0_d ? bus.rom_code : rdata0_q;
    rdata1_d   = rvalid1_d ? bus.rom_code : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= 5'd0;
      rom_xy_q   <= 8'd0;
      rom_line_q <= 4'd0;
      tag_vld_q  <= 1'b0;
      tag_port_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 11'd0;
      rdata1_q   <= 11'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rom_xy_q   <= rom_xy_d;
      rom_line_q <= rom_line_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rom_xy   = rom_xy_q;
  assign bus.rom_line = rom_line_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed and randomised checks of char_rom_arbiter; a round-robin instance
// carries most scenarios and a fixed-priority instance covers RR_EN = 0.
module tb_char_rom_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  char_rom_arbiter_if bus ();
  char_rom_arbiter_if bus_fp ();

  char_rom_arbiter #(.RR_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  char_rom_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  function automatic logic [10:0] rom_fn(input logic [7:0] xy, input logic [3:0] ln);
    return {ln[2:0], xy} ^ 11'h2A5;
  endfunction

  assign bus.rom_code    = rom_fn(bus.rom_xy, bus.rom_line);
  assign bus_fp.rom_code = rom_fn(bus_fp.rom_xy, bus_fp.rom_line);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.xy0 = 0; bus.xy1 = 0; bus.line0 = 0; bus.line1 = 0;
    bus_fp.req0 = 0; bus_fp.req1 = 0; bus_fp.lock0 = 0; bus_fp.lock1 = 0;
    bus_fp.xy0 = 0; bus_fp.xy1 = 0; bus_fp.line0 = 0; bus_fp.line1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req0 = 1; bus.req1 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      fails++; $display("FAIL reset_gnt: got %b expected 00", {bus.gnt0, bus.gnt1});
    end
    tests++;
    if ({bus.rom_xy, bus.rom_line} !== 12'h000) begin
      fails++; $display("FAIL reset_rom_addr: got %h expected 000", {bus.rom_xy, bus.rom_line});
    end
    tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1} !== 24'h0) begin
      fails++; $display("FAIL reset_results: got %h expected 0", {bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1});
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    bus.req0 = 1; bus.xy0 = 8'h70; bus.line0 = 4'd3;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      fails++; $display("FAIL single_gnt: got %b expected 10", {bus.gnt0, bus.gnt1});
    end
    @(posedge clk); #1;
    bus.req0 = 0;
    @(negedge clk);
    tests++;
    if ({bus.rom_xy, bus.rom_line, bus.rvalid0, bus.rvalid1} !== {8'h70, 4'd3, 2'b00}) begin
      fails++; $display("FAIL single_n1: got xy=%h line=%h rv=%b%b expected xy=70 line=3 rv=00",
                        bus.rom_xy, bus.rom_line, bus.rvalid0, bus.rvalid1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata0} !== {2'b10, rom_fn(8'h70, 4'd3)}) begin
      fails++; $display("FAIL single_n2: got rv=%b%b rdata0=%h expected rv=10 rdata0=%h",
                        bus.rvalid0, bus.rvalid1, bus.rdata0, rom_fn(8'h70, 4'd3));
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rom_xy} !== {2'b00, rom_fn(8'h70, 4'd3), 8'h70}) begin
      fails++; $display("FAIL single_hold: got rv=%b%b rdata0=%h xy=%h expected rv=00 rdata0=%h xy=70",
                        bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rom_xy, rom_fn(8'h70, 4'd3));
    end
    @(posedge clk); #1;
    $display("[TB] test_single done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic [1:0] exp_v;
    do_reset();
    bus.req0 = 1; bus.xy0 = 8'h12; bus.line0 = 4'h1;
    bus.req1 = 1; bus.xy1 = 8'h34; bus.line1 = 4'h2;
    bus_fp.req0 = 1; bus_fp.req1 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      tests++;
      if ({bus.gnt0, bus.gnt1} !== exp_g) begin
        fails++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {bus.gnt0, bus.gnt1}, exp_g);
      end
      tests++;
      if ({bus_fp.gnt0, bus_fp.gnt1} !== 2'b10) begin
        fails++; $display("FAIL fp_gnt[%0d]: got %b expected 10", i, {bus_fp.gnt0, bus_fp.gnt1});
      end
      if (i >= 2) begin
        exp_v = exp_g;
        tests++;
        if ({bus.rvalid0, bus.rvalid1} !== exp_v ||
            (exp_v[1] && bus.rdata0 !== rom_fn(8'h12, 4'h1)) ||
            (exp_v[0] && bus.rdata1 !== rom_fn(8'h34, 4'h2))) begin
          fails++; $display("FAIL rr_rvalid[%0d]: got rv=%b d0=%h d1=%h expected rv=%b d0=%h d1=%h",
                            i, {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1, exp_v,
                            rom_fn(8'h12, 4'h1), rom_fn(8'h34, 4'h2));
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_lock();
    logic exp_g1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.req0  = 1;
      bus.req1  = (c >= 1 && c <= 5) || c == 7;
      bus.lock1 = (c >= 1 && c <= 5);
      exp_g1    = (c >= 1 && c <= 5) || c == 7;
      @(negedge clk);
      tests++;
      if ({bus.gnt0, bus.gnt1} !== {!exp_g1, exp_g1}) begin
        fails++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c, {bus.gnt0, bus.gnt1}, {!exp_g1, exp_g1});
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] test_lock done");
  endtask

  task automatic test_lock_limit();
    logic exp_g1;
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.req1 = 1;
    for (int i = 0; i < 20; i++) begin
      exp_g1 = (i == 16);
      @(negedge clk);
      tests++;
      if ({bus.gnt0, bus.gnt1} !== {!exp_g1, exp_g1}) begin
        fails++; $display("FAIL lock_limit_gnt[%0d]: got %b expected %b", i, {bus.gnt0, bus.gnt1}, {!exp_g1, exp_g1});
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] test_lock_limit done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req1 = 1; bus.xy1 = 8'h5C; bus.line1 = 4'h7;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      fails++; $display("FAIL midrst_gnt: got %b expected 01", {bus.gnt0, bus.gnt1});
    end
    @(posedge clk); #1;
    bus.req1 = 0; bus.req0 = 1; rst = 1;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      fails++; $display("FAIL midrst_gnt_in_rst: got %b expected 00", {bus.gnt0, bus.gnt1});
    end
    @(posedge clk); #1;
    rst = 0; bus.req0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({bus.rvalid0, bus.rvalid1, bus.rdata1, bus.rom_xy} !== 21'h0) begin
        fails++; $display("FAIL midrst_quiet[%0d]: got rv=%b%b d1=%h xy=%h expected all 0",
                          k, bus.rvalid0, bus.rvalid1, bus.rdata1, bus.rom_xy);
      end
      @(posedge clk); #1;
    end
    bus.req0 = 1; bus.xy0 = 8'hA5; bus.line0 = 4'h9;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      fails++; $display("FAIL midrst_regnt: got %b expected 10", {bus.gnt0, bus.gnt1});
    end
    @(posedge clk); #1;
    bus.req0 = 0;
    @(negedge clk);
    tests++;
    if (bus.rvalid0 !== 1'b0) begin
      fails++; $display("FAIL midrst_early: got rvalid0=%b expected 0", bus.rvalid0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({bus.rvalid0, bus.rdata0} !== {1'b1, rom_fn(8'hA5, 4'h9)}) begin
      fails++; $display("FAIL midrst_result: got rv0=%b d0=%h expected rv0=1 d0=%h",
                        bus.rvalid0, bus.rdata0, rom_fn(8'hA5, 4'h9));
    end
    @(posedge clk); #1;
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] exp;
    logic        pend0, pend1;
    pend0 = 0; pend1 = 0;
    do_reset();
    for (int cyc = 0; cyc < 340; cyc++) begin
      if (cyc < 300 && !pend0 && $urandom_range(0, 99) < 60) begin
        pend0 = 1; bus.xy0 = 8'($urandom); bus.line0 = 4'($urandom);
      end
      if (cyc < 300 && !pend1 && $urandom_range(0, 99) < 60) begin
        pend1 = 1; bus.xy1 = 8'($urandom); bus.line1 = 4'($urandom);
      end
      bus.req0 = pend0; bus.req1 = pend1;
      bus.lock0 = 1'($urandom); bus.lock1 = 1'($urandom);
      @(negedge clk);
      tests++;
      if ((bus.gnt0 && bus.gnt1) || (bus.gnt0 && !bus.req0) || (bus.gnt1 && !bus.req1)) begin
        fails++; $display("FAIL rand_gnt[%0d]: got gnt=%b req=%b expected one-hot within req",
                          cyc, {bus.gnt0, bus.gnt1}, {bus.req0, bus.req1});
      end
      if (bus.rvalid0) begin
        tests++;
        exp = (q0.size() > 0) ? q0.pop_front() : 11'h7FF;
        if (bus.rdata0 !== exp) begin
          fails++; $display("FAIL rand_rdata0[%0d]: got %h expected %h", cyc, bus.rdata0, exp);
        end
      end
      if (bus.rvalid1) begin
        tests++;
        exp = (q1.size() > 0) ? q1.pop_front() : 11'h7FF;
        if (bus.rdata1 !== exp) begin
          fails++; $display("FAIL rand_rdata1[%0d]: got %h expected %h", cyc, bus.rdata1, exp);
        end
      end
      if (bus.gnt0) begin q0.push_back(rom_fn(bus.xy0, bus.line0)); pend0 = 0; end
      if (bus.gnt1) begin q1.push_back(rom_fn(bus.xy1, bus.line1)); pend1 = 0; end
      @(posedge clk); #1;
    end
    tests++;
    if (q0.size() != 0 || q1.size() != 0 || pend0 || pend1) begin
      fails++; $display("FAIL rand_drain: got q0=%0d q1=%0d pend=%b%b expected 0 0 00",
                        q0.size(), q1.size(), pend0, pend1);
    end
    idle_inputs();
    $display("[TB] test_random done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_lock();
    test_lock_limit();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/char_rom_arbiter.md
CHAR_ROM_ARBITER -- requirements
Module: char_rom_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin between ports, 0 = fixed priority with port 0 winning.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  port n requests one glyph-line lookup.
REQ-005 lock0 / lock1  input  1  port n asks to keep ownership after the current grant (string burst).
REQ-006 xy0 / xy1  input  8  port n character cell, [7:4] column, [3:0] row.
REQ-007 line0 / line1  input  4  port n glyph pixel line.
REQ-008 gnt0 / gnt1  output  1  combinational grant; the request is consumed in the cycle where reqn and gntn are both 1.
REQ-009 rvalid0 / rvalid1  output  1  one-cycle pulse; rdatan is valid.
REQ-010 rdata0 / rdata1  output  11  returned char_code for port n.
REQ-011 rom_xy  output  8  registered cell address to the char ROM.
REQ-012 rom_line  output  4  registered glyph line to the char ROM.
REQ-013 rom_code  input  11  combinational char ROM result for rom_xy/rom_line.

Function
REQ-014 At most one of gnt0/gnt1 SHALL be 1 in any cycle, and gntn SHALL be 1 only when reqn = 1.
REQ-015 The FSM SHALL have the states IDLE, OWN0 and OWN1.
REQ-016 In IDLE with one request, that port SHALL be granted.
REQ-017 In IDLE with both requests and RR_EN = 1, the port not granted most recently SHALL win; after reset, port 0 SHALL win.
REQ-018 In IDLE with both requests and RR_EN = 0, port 0 SHALL win.
REQ-019 A grant to port n with lockn = 1 SHALL move the FSM to OWNn.
REQ-020 A grant with lockn = 0 SHALL return the FSM to, or keep it in, IDLE.
REQ-021 In OWNn, port n SHALL receive the grant whenever reqn = 1, regardless of the other port.
REQ-022 In OWNn, the FSM SHALL return to IDLE when lockn = 0 or reqn = 0; in that same cycle the other port SHALL be granted if it is requesting.
REQ-023 A lock SHALL NOT be held longer than 16 consecutive grants; on the 16th grant the FSM SHALL go to IDLE, and that port SHALL lose the next tie.
REQ-024 A consumed request SHALL register xyn/linen into rom_xy/rom_line on the next edge (cycle N+1).
REQ-025 rom_xy/rom_line SHALL hold their last value when nothing is consumed.
REQ-026 rom_code SHALL be captured into rdatan and rvalidn SHALL pulse at cycle N+2: fixed latency 2, fully pipelined, one result per cycle.
REQ-027 A tag pipeline (valid + port id, 2 stages) SHALL route each result to the port that issued it, in issue order.
REQ-028 rdatan SHALL hold its value between pulses.
REQ-029 Back-to-back consumes from alternating ports SHALL produce alternating rvalid pulses with no bubble.
REQ-030 Requests SHALL NOT be lost or duplicated; a requester holds req/xy/line stable until it is granted.

Reset
REQ-031 While rst = 1 on an edge, the block SHALL set the FSM to IDLE, the round-robin pointer to favour port 0, and the lock counter to 0.
REQ-032 While rst = 1 on an edge, the block SHALL set rom_xy = 0, rom_line = 0, rdata0 = rdata1 = 0, rvalid0 = rvalid1 = 0, and the tag pipeline to invalid.
REQ-033 gnt0/gnt1 SHALL be 0 during any cycle where rst = 1.
REQ-034 Reset mid-operation SHALL discard in-flight lookups, producing no rvalid pulse for them after rst deasserts.

Verification
REQ-035 req0 = 1, xy0 = 8'h70, line0 = 3 alone -> gnt0 = 1 at N, rom_xy = 8'h70 and rom_line = 3 at N+1, rvalid0 pulse with rdata0 = rom_code at N+2, rvalid1 = 0 throughout.
REQ-036 req0 = req1 = 1 continuously, lock = 0, RR_EN = 1 -> grants alternate 0,1,0,1, starting with port 0 after reset; with RR_EN = 0 -> port 0 is granted every cycle.
REQ-037 Port 1 issues 5 requests with lock1 = 1 while req0 = 1 -> 5 consecutive gnt1, then gnt0 in the cycle lock1 drops.
REQ-038 Lock held with 20 continuous requests, other port also requesting -> after the 16th grant the other port is granted once.
REQ-039 rst pulsed one cycle after a grant -> no rvalid for that request, all outputs 0, the next request completes with latency 2.
REQ-040 Random req/lock/xy/line on both ports against a reference model -> one-hot grants, every consumed request returns exactly once to the correct port with the correct rom_code.
